// File: rtl/cdc_handshake_tx.sv
// rtl/cdc_handshake_tx.sv - 4-phase req/ack CDC transmitter with synchronized acknowledge
// Optional ack-wait timeout is built when CDC_HS_TIMEOUT_EN is defined.
module cdc_handshake_tx #(
  parameter int BUS_WIDTH      = 8,
  parameter int STAGE_COUNT    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in_data,
  output logic                 xfer_req,
  output logic [BUS_WIDTH-1:0] xfer_data,
  input  logic                 xfer_ack,
  output logic                 busy,
  input  logic                 err_clr,
  output logic                 err_timeout
);

  localparam int SYNC_N = (STAGE_COUNT < 2) ? 2 : STAGE_COUNT;

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t                 r_state;
  logic [SYNC_N-1:0]      r_ack_sync;
  logic                   r_req;
  logic [BUS_WIDTH-1:0]   r_data;
  logic                   w_ack_s;
  logic                   w_in_ready;
  logic                   w_timeout;

  assign w_ack_s    = r_ack_sync[SYNC_N-1];
  // A stale ack still high from a previous transfer must drain before a new request.
  assign w_in_ready = (r_state == IDLE) && !w_ack_s;

  assign in_ready  = w_in_ready;
  assign busy      = (r_state != IDLE);
  assign xfer_req  = r_req;
  assign xfer_data = r_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_N-2:0], xfer_ack};
    end
  end

`ifdef CDC_HS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // r_cnt holds completed cycles in REQ; the edge ending the TIMEOUT_CYCLES-th cycle times out.
  assign w_timeout   = (r_state == REQ) && !w_ack_s && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err_timeout = r_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        r_cnt <= '0;
      end else if (r_state == REQ && !w_ack_s && !w_timeout) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end
`else
  logic w_unused_cfg;

  assign w_timeout    = 1'b0;
  assign err_timeout  = 1'b0;
  assign w_unused_cfg = err_clr ^ (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && w_in_ready) begin
            r_data  <= in_data;
            r_req   <= 1'b1;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (w_ack_s || w_timeout) begin
            r_req   <= 1'b0;
            r_state <= DROP;
          end
        end
        DROP: begin
          if (!w_ack_s) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cdc_handshake_tx.md
CDC_HANDSHAKE_TX -- requirements
Module: cdc_handshake_tx

Interface
REQ-001 Parameters SHALL be: BUS_WIDTH, 8, payload width; STAGE_COUNT, 2, flops in the ack synchronizer chain (min 2); TIMEOUT_CYCLES, 255, ack wait limit when timeout feature built.
REQ-002 Ports SHALL be:
- clk  input  1  clock.
- reset_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  source has a word.
- in_ready  output  1  block can accept a word.
- in_data  input  BUS_WIDTH  word to send.
- xfer_req  output  BUS_WIDTH-independent 1  4-phase request to destination domain, registered.
- xfer_data  output  BUS_WIDTH  payload to destination, registered, held stable while handshake open.
- xfer_ack  input  1  4-phase acknowledge from destination domain, asynchronous to clk.
- busy  output  1  handshake in progress.
- err_clr  input  1  clears err_timeout.
- err_timeout  output  1  sticky timeout flag.

Function
REQ-003 xfer_ack SHALL pass through STAGE_COUNT reset-cleared flops clocked by clk before any use; the FSM SHALL use only the last stage (ack_s).
REQ-004 FSM states SHALL be IDLE, REQ, DROP; encoding free.
REQ-005 in_ready SHALL be 1 only in IDLE with ack_s==0; busy SHALL be 1 whenever state != IDLE.
REQ-006 Accept = in_valid & in_ready at a clk edge: xfer_data <= in_data, xfer_req <= 1, state <= REQ, all at that same edge.
REQ-007 in_valid while in_ready==0 SHALL be ignored; xfer_data SHALL not change.
REQ-008 REQ: when ack_s==1 at an edge, xfer_req <= 0, state <= DROP.
REQ-009 DROP: when ack_s==0 at an edge, state <= IDLE; xfer_data SHALL keep its value until next accept.
REQ-010 xfer_data SHALL be stable from the accept edge until xfer_req has fallen and ack_s==0.
REQ-011 ack_s==1 in IDLE (spurious or stale ack) SHALL hold in_ready low; no request issued until ack_s returns to 0.
REQ-012 With destination echoing xfer_req onto xfer_ack, xfer_req SHALL be high for STAGE_COUNT+1 cycles and accept-to-accept period SHALL be 2*STAGE_COUNT+3 cycles.

Reset
REQ-013 reset_n low SHALL immediately force: state IDLE, xfer_req 0, xfer_data 0, synchronizer flops 0, timeout counter 0, err_timeout 0; in_ready 1 and busy 0 once reset_n is released.
REQ-014 Reset mid-handshake SHALL abandon the transfer with no retry; destination recovery is the destination's job.

Configuration
REQ-015 Macro CDC_HS_TIMEOUT_EN defined: counter SHALL count cycles spent in REQ (cleared on entry); reaching TIMEOUT_CYCLES with ack_s still 0 SHALL set err_timeout and move to DROP, dropping xfer_req.
REQ-016 err_timeout SHALL stay set until err_clr==1 at an edge; set and clear in the same cycle SHALL leave it set.
REQ-017 Macro undefined: no counter logic; err_timeout SHALL be constant 0, err_clr ignored; ports SHALL exist in both builds.

Verification
REQ-018 Reset release, in_valid=1, in_data=8'hA5, xfer_ack looped from xfer_req -> xfer_data=8'hA5 after the accept edge, xfer_req high 3 cycles, in_ready back 1 six cycles after the accept edge (next accept at the 7th edge).
REQ-019 Back-to-back words 8'h01, 8'h02, 8'h03 with loopback -> each seen once on xfer_data in order, accepts exactly 7 cycles apart, xfer_data never changes while xfer_req=1.
REQ-020 in_data changes every cycle while busy -> xfer_data unchanged until next accept.
REQ-021 xfer_ack forced high while IDLE -> in_ready 0 and no xfer_req until 2 cycles after ack falls.
REQ-022 CDC_HS_TIMEOUT_EN, TIMEOUT_CYCLES=10, xfer_ack tied 0 -> xfer_req falls after 10 cycles in REQ, err_timeout=1, IDLE one cycle later; err_clr pulse -> err_timeout=0.
REQ-023 reset_n pulsed low while in REQ -> xfer_req, xfer_data, busy 0 during reset; in_ready 1 after release.
